// File: rtl/map_pkg.sv
`default_nettype none
// ============================================================================
// Module   : map_pkg
// Purpose  : Shared board-map geometry, card codes and index types.
// Revision : 1.0 - initial release
// ============================================================================
package map_pkg;

  localparam int MAP_ROWS = 8;
  localparam int MAP_COLS = 18;
  localparam int CELLS    = 144;
  localparam int CODE_W   = 6;

  typedef logic [7:0]        cell_idx_t;
  typedef logic [CODE_W-1:0] card_code_t;

  localparam card_code_t EMPTY_CODE = 6'd63;

  function automatic logic is_empty(input card_code_t code);
    return code == EMPTY_CODE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/map_cell_editor_pixel_to_cell.sv
`default_nettype none
// ============================================================================
// Module   : pixel_to_cell
// Purpose  : Registered hit-test mapping a cursor pixel to a board cell index.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_to_cell
  import map_pkg::*;
#(
  parameter int ORIGIN_X = 32,
  parameter int ORIGIN_Y = 48,
  parameter int CELL_W   = 32,
  parameter int CELL_H   = 48
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic      valid,
  output logic      hit,
  output cell_idx_t idx,
  output logic      valid_q
);

  localparam logic [10:0] c_x_end = 11'(ORIGIN_X + MAP_COLS * CELL_W);
  localparam logic [10:0] c_y_end = 11'(ORIGIN_Y + MAP_ROWS * CELL_H);

  // Thermometer code of column/row boundaries crossed; bit 0 is the left/top edge.
  logic [MAP_COLS-1:0] w_col_ge;
  logic [MAP_ROWS-1:0] w_row_ge;
  logic [4:0]          w_col;
  logic [2:0]          w_row;
  logic                w_in;
  cell_idx_t           w_idx;

  generate
    for (genvar k = 0; k < MAP_COLS; k++) begin : g_col
      localparam logic [10:0] c_bound = 11'(ORIGIN_X + k * CELL_W);
      assign w_col_ge[k] = {1'b0, mouse_x} >= c_bound;
    end
    for (genvar k = 0; k < MAP_ROWS; k++) begin : g_row
      localparam logic [10:0] c_bound = 11'(ORIGIN_Y + k * CELL_H);
      assign w_row_ge[k] = {1'b0, mouse_y} >= c_bound;
    end
  endgenerate

  always_comb begin
    w_col = '0;
    w_row = '0;
    for (int k = 1; k < MAP_COLS; k++) w_col = w_col + 5'(w_col_ge[k]);
    for (int k = 1; k < MAP_ROWS; k++) w_row = w_row + 3'(w_row_ge[k]);
    w_in  = w_col_ge[0] && w_row_ge[0] &&
            ({1'b0, mouse_x} < c_x_end) && ({1'b0, mouse_y} < c_y_end);
    w_idx = 8'(w_row) * 8'(MAP_COLS) + 8'(w_col);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      hit     <= 1'b0;
      idx     <= '0;
    end else begin
      valid_q <= valid & ~flush;
      hit     <= w_in;
      idx     <= w_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/map_cell_editor.sv
`default_nettype none
// ============================================================================
// Module   : map_cell_editor
// Purpose  : Owns the 8x18 card map and highlight vector, edited by mouse clicks.
//            Optional macro MAP_EDIT_SWAP_EN: clicking another card while one is
//            held swaps the two instead of reselecting.
// Revision : 1.0 - initial release
// ============================================================================
module map_cell_editor
  import map_pkg::*;
#(
  parameter int ORIGIN_X = 32,
  parameter int ORIGIN_Y = 48,
  parameter int CELL_W   = 32,
  parameter int CELL_H   = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [9:0]   mouse_x,
  input  logic [9:0]   mouse_y,
  input  logic         l_click,
  input  logic         r_click,
  input  logic         load_en,
  input  logic [863:0] load_map,
  output logic [863:0] map,
  output logic [143:0] sel_card,
  output logic         busy,
  output logic         move_done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t       r_state, w_state_nxt;
  card_code_t   r_cells [CELLS];
  cell_idx_t    r_src, w_src_nxt;
  logic [143:0] r_sel, w_sel_nxt;
  logic         r_move_done, w_move_done_nxt;
  logic         r_act_q;
  logic         w_start, w_hit, w_valid_q;
  cell_idx_t    w_idx;
  logic         w_wr_en;
  card_code_t   w_tgt_code, w_src_code;
  logic [143:0] w_onehot;

  assign busy      = w_valid_q | r_act_q;
  assign w_start   = l_click & ~busy & ~load_en;
  assign sel_card  = r_sel;
  assign move_done = r_move_done;

  pixel_to_cell #(
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y),
    .CELL_W   (CELL_W),
    .CELL_H   (CELL_H)
  ) u_pixel_to_cell (
    .clk     (clk),
    .rst     (rst),
    .flush   (load_en),
    .mouse_x (mouse_x),
    .mouse_y (mouse_y),
    .valid   (w_start),
    .hit     (w_hit),
    .idx     (w_idx),
    .valid_q (w_valid_q)
  );

  generate
    for (genvar i = 0; i < CELLS; i++) begin : g_map
      assign map[i*CODE_W+CODE_W-1 -: CODE_W] = r_cells[i];
    end
  endgenerate

  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src;
    w_sel_nxt       = r_sel;
    w_move_done_nxt = 1'b0;
    w_wr_en         = 1'b0;
    w_tgt_code      = r_cells[w_idx];
    w_src_code      = EMPTY_CODE;
    w_onehot        = {{(CELLS-1){1'b0}}, 1'b1} << w_idx;

    // Load beats cancel, and cancel beats a pending click action.
    if (load_en) begin
      w_state_nxt = ST_IDLE;
      w_sel_nxt   = '0;
    end else if (r_click && r_state == ST_HELD) begin
      w_state_nxt = ST_IDLE;
      w_sel_nxt   = '0;
    end else if (w_valid_q && w_hit) begin
      case (r_state)
        ST_IDLE: begin
          if (!is_empty(w_tgt_code)) begin
            w_src_nxt   = w_idx;
            w_sel_nxt   = w_onehot;
            w_state_nxt = ST_HELD;
          end
        end
        ST_HELD: begin
          if (w_idx == r_src) begin
            w_sel_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else if (is_empty(w_tgt_code)) begin
            w_wr_en         = 1'b1;
            w_sel_nxt       = '0;
            w_move_done_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
          end else begin
`ifdef MAP_EDIT_SWAP_EN
            w_wr_en         = 1'b1;
            w_src_code      = w_tgt_code;
            w_sel_nxt       = '0;
            w_move_done_nxt = 1'b1;
            w_state_nxt     = ST_IDLE;
`else
            w_src_nxt = w_idx;
            w_sel_nxt = w_onehot;
`endif
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_src       <= '0;
      r_sel       <= '0;
      r_move_done <= 1'b0;
      r_act_q     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_src       <= w_src_nxt;
      r_sel       <= w_sel_nxt;
      r_move_done <= w_move_done_nxt;
      r_act_q     <= w_valid_q & ~load_en;
    end
  end

  // Target takes the held code; source becomes empty (move) or the old target code (swap).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) r_cells[i] <= EMPTY_CODE;
    end else if (load_en) begin
      for (int i = 0; i < CELLS; i++) r_cells[i] <= load_map[i*CODE_W+CODE_W-1 -: CODE_W];
    end else if (w_wr_en) begin
      r_cells[w_idx] <= r_cells[r_src];
      r_cells[r_src] <= w_src_code;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_map_cell_editor.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_cell_editor
// Purpose  : Directed self-checking bench with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_cell_editor;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [9:0]   mouse_x = '0;
  logic [9:0]   mouse_y = '0;
  logic         l_click = 1'b0;
  logic         r_click = 1'b0;
  logic         load_en = 1'b0;
  logic [863:0] load_map = '0;
  logic [863:0] map;
  logic [143:0] sel_card;
  logic         busy;
  logic         move_done;

  int total = 0;
  int bad   = 0;

  map_cell_editor dut (
    .clk       (clk),
    .rst       (rst),
    .mouse_x   (mouse_x),
    .mouse_y   (mouse_y),
    .l_click   (l_click),
    .r_click   (r_click),
    .load_en   (load_en),
    .load_map  (load_map),
    .map       (map),
    .sel_card  (sel_card),
    .busy      (busy),
    .move_done (move_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_map(input string name, input logic [863:0] act, input logic [863:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      for (int i = 0; i < 144; i++)
        if (act[i*6+5 -: 6] !== exp[i*6+5 -: 6]) begin
          $display("FAIL %s cell %0d actual=%0d required=%0d", name, i,
                   act[i*6+5 -: 6], exp[i*6+5 -: 6]);
          break;
        end
    end
  endtask

  function automatic logic [863:0] pattern(input bit empty_last);
    logic [863:0] v;
    for (int i = 0; i < 144; i++)
      v[i*6+5 -: 6] = (empty_last && i == 143) ? 6'd63 : 6'(i % 55);
    return v;
  endfunction

  // ---------------- reference model ----------------
  int m_map [144];
  bit m_held, m_done, m_ready;
  int m_src, m_sel, m_age, m_px, m_py;

  function automatic int hit_idx(input int x, input int y);
    if (x < 32 || x >= 32 + 18*32 || y < 48 || y >= 48 + 8*48) return -1;
    return ((y - 48) / 48) * 18 + (x - 32) / 32;
  endfunction

  always @(posedge clk) begin
    int age_old, h, t;
    if (rst) begin
      for (int i = 0; i < 144; i++) m_map[i] = 63;
      m_held = 0; m_sel = -1; m_done = 0; m_age = 0; m_src = 0; m_ready = 1;
    end else if (load_en) begin
      for (int i = 0; i < 144; i++) m_map[i] = int'(load_map[i*6+5 -: 6]);
      m_held = 0; m_sel = -1; m_done = 0; m_age = 0;
    end else begin
      age_old = m_age;
      m_done  = 0;
      h = (age_old == 1) ? hit_idx(m_px, m_py) : -1;
      if (r_click && m_held) begin
        m_held = 0; m_sel = -1;
      end else if (h >= 0) begin
        if (!m_held) begin
          if (m_map[h] != 63) begin m_held = 1; m_src = h; m_sel = h; end
        end else if (h == m_src) begin
          m_held = 0; m_sel = -1;
        end else if (m_map[h] == 63) begin
          m_map[h] = m_map[m_src]; m_map[m_src] = 63;
          m_held = 0; m_sel = -1; m_done = 1;
        end else begin
`ifdef MAP_EDIT_SWAP_EN
          t = m_map[h]; m_map[h] = m_map[m_src]; m_map[m_src] = t;
          m_held = 0; m_sel = -1; m_done = 1;
`else
          t = 0;
          m_src = h; m_sel = h;
`endif
        end
      end
      m_age = (age_old == 1) ? 2 : 0;
      if (l_click && age_old == 0) begin
        m_age = 1; m_px = int'(mouse_x); m_py = int'(mouse_y);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [863:0] em;
    logic [143:0] es;
    logic [143:0] one;
    if (m_ready) begin
      one = 144'd1;
      for (int i = 0; i < 144; i++) em[i*6+5 -: 6] = 6'(m_map[i]);
      es = (m_sel < 0) ? '0 : (one << m_sel);
      chk_map("model_map", map, em);
      chk("model_sel", sel_card, es);
      chk("model_busy", {143'd0, busy}, {143'd0, m_age != 0});
      chk("model_done", {143'd0, move_done}, {143'd0, m_done});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Leaves the bench in cycle N+2 of the click.
  task automatic click(input int x, input int y);
    cyc(1);
    mouse_x = 10'(x); mouse_y = 10'(y); l_click = 1'b1;
    cyc(1);
    l_click = 1'b0;
    cyc(1);
  endtask

  task automatic rclick();
    cyc(1); r_click = 1'b1;
    cyc(1); r_click = 1'b0;
  endtask

  task automatic load(input logic [863:0] v);
    cyc(1); load_map = v; load_en = 1'b1;
    cyc(1); load_en = 1'b0;
  endtask

  initial begin
    logic [143:0] one;
    logic [863:0] all_empty;
    logic [863:0] exp_map;
    one = 144'd1;
    for (int i = 0; i < 144; i++) all_empty[i*6+5 -: 6] = 6'd63;

    cyc(3);
    rst = 1'b0;
    chk_map("reset_map", map, all_empty);
    chk("reset_sel", sel_card, '0);
    chk("reset_busy", {143'd0, busy}, '0);

    // 1: load and first pick
    load(pattern(0));
    chk_map("load_map", map, pattern(0));
    click(40, 50);
    chk("pick_idx0", sel_card, 144'h1);
    cyc(1);
    chk("busy_clear", {143'd0, busy}, '0);
    rclick();
    chk("cancel0", sel_card, '0);

    // 2: pick 20, move to empty 143
    load(pattern(1));
    click(100, 100);
    chk("pick_idx20", sel_card, one << 20);
    click(590, 420);
    chk("move_done_pulse", {143'd0, move_done}, 144'd1);
    chk("move_tgt", {138'd0, map[143*6+5 -: 6]}, 144'd20);
    chk("move_src", {138'd0, map[20*6+5 -: 6]}, 144'd63);
    chk("move_sel", sel_card, '0);
    cyc(1);
    chk("done_once", {143'd0, move_done}, '0);

    // 3: misses and the bottom-right pixel
    exp_map = map;
    click(10, 10);
    chk("miss_origin", sel_card, '0);
    click(608, 48);
    chk("miss_right", sel_card, '0);
    chk_map("miss_map", map, exp_map);
    click(607, 431);
    chk("pick_idx143", sel_card, one << 143);
    rclick();

    // 4: deselect by same cell, cancel by right click
    click(40, 50);
    click(40, 50);
    chk("deselect", sel_card, '0);
    click(40, 50);
    rclick();
    chk("rclick_cancel", sel_card, '0);
    chk_map("rclick_map", map, exp_map);

    // 5: back-to-back clicks, load during HELD, load mid-pipeline
    cyc(1);
    mouse_x = 10'd40; mouse_y = 10'd50; l_click = 1'b1;
    cyc(1);
    mouse_x = 10'd100; mouse_y = 10'd100;
    chk("busy_n1", {143'd0, busy}, 144'd1);
    cyc(1); l_click = 1'b0;
    cyc(3);
    chk("second_dropped", sel_card, 144'h1);
    load(pattern(0));
    chk("load_clears_sel", sel_card, '0);
    chk_map("load_in_held", map, pattern(0));
    cyc(1);
    mouse_x = 10'd40; mouse_y = 10'd50; l_click = 1'b1;
    cyc(1); l_click = 1'b0; load_en = 1'b1; load_map = pattern(1);
    cyc(1); load_en = 1'b0;
    chk("load_flush_busy", {143'd0, busy}, '0);
    cyc(2);
    chk("load_flush_sel", sel_card, '0);

    // 6: second card while held
    click(40, 50);
    click(72, 50);
`ifdef MAP_EDIT_SWAP_EN
    chk("swap_c0", {138'd0, map[5:0]}, 144'd1);
    chk("swap_c1", {138'd0, map[11:6]}, 144'd0);
    chk("swap_done", {143'd0, move_done}, 144'd1);
    chk("swap_sel", sel_card, '0);
`else
    chk("reselect", sel_card, 144'h2);
    chk("reselect_map", {132'd0, map[11:0]}, {132'd0, 6'd1, 6'd0});
`endif
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_again_sel", sel_card, '0);
    chk_map("rst_again_map", map, all_empty);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
